// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 subset control FSM: Moore-decoded datapath controls,
// memory wait-state handshake and a sticky illegal-opcode trap.
module multicycle_control_unit #(
  parameter int ALUCTRL_W     = 4,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                 i_cu_clk,
  input  logic                 i_cu_rst,
  input  logic [6:0]           i_cu_op,
  input  logic [2:0]           i_cu_funct3,
  input  logic                 i_cu_funct7_5,
  input  logic                 i_cu_zero,
  input  logic                 i_cu_mem_ready,
  output logic                 o_cu_PCWrite,
  output logic                 o_cu_AdrSrc,
  output logic                 o_cu_MemWrite,
  output logic                 o_cu_IRWrite,
  output logic                 o_cu_RegWrite,
  output logic [1:0]           o_cu_ResultSrc,
  output logic [1:0]           o_cu_ALUSrcA,
  output logic [1:0]           o_cu_ALUSrcB,
  output logic [2:0]           o_cu_ImmSrc,
  output logic [ALUCTRL_W-1:0] o_cu_ALUControl,
  output logic                 o_cu_illegal,
  output logic [3:0]           o_cu_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  state_t     r_state;
  state_t     w_next;
  state_t     w_out_state;
  logic       r_illegal;
  logic       w_ready;
  logic [3:0] w_alu_dec;
  logic [3:0] w_alu;
  logic       w_pcw, w_adr, w_memw, w_irw, w_regw;
  logic [1:0] w_res, w_srca, w_srcb;
  logic [2:0] w_imm;

  assign w_ready = MEM_HANDSHAKE ? i_cu_mem_ready : 1'b1;

  always_ff @(posedge i_cu_clk) begin
    if (i_cu_rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_cu_op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_LUI:            w_next = S_LUI;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (i_cu_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB, S_BRANCH, S_ALUWB: w_next = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI: w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      // unused encodings are treated as a fault and parked in the trap
      default:    w_next = S_TRAP;
    endcase
  end

  always_comb begin
    w_alu_dec = ALU_ADD;
    case (i_cu_funct3)
      3'b000:  w_alu_dec = (r_state == S_EXECR && i_cu_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_dec = ALU_SLL;
      3'b010:  w_alu_dec = ALU_SLT;
      3'b011:  w_alu_dec = ALU_SLTU;
      3'b100:  w_alu_dec = ALU_XOR;
      3'b101:  w_alu_dec = i_cu_funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_dec = ALU_OR;
      3'b111:  w_alu_dec = ALU_AND;
      default: w_alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    w_imm = 3'b000;
    case (i_cu_op)
      OP_LOAD, OP_ITYPE: w_imm = 3'b000;
      OP_STORE:          w_imm = 3'b001;
      OP_BRANCH:         w_imm = 3'b010;
      OP_JAL:            w_imm = 3'b011;
      OP_LUI:            w_imm = 3'b100;
      default:           w_imm = 3'b000;
    endcase
  end

  // while in reset the selects look like FETCH; enables are masked below
  assign w_out_state = i_cu_rst ? S_FETCH : r_state;

  always_comb begin
    w_pcw  = 1'b0;
    w_adr  = 1'b0;
    w_memw = 1'b0;
    w_irw  = 1'b0;
    w_regw = 1'b0;
    w_res  = 2'b00;
    w_srca = 2'b00;
    w_srcb = 2'b00;
    w_alu  = ALU_ADD;
    case (w_out_state)
      S_FETCH: begin
        w_srcb = 2'b10;
        w_res  = 2'b10;
        w_irw  = w_ready;
        w_pcw  = w_ready;
      end
      S_DECODE: begin
        w_srca = 2'b01;
        w_srcb = 2'b01;
      end
      S_MEMADR: begin
        w_srca = 2'b10;
        w_srcb = 2'b01;
      end
      S_MEMREAD:  w_adr = 1'b1;
      S_MEMWRITE: begin
        w_adr  = 1'b1;
        w_memw = 1'b1;
      end
      S_MEMWB: begin
        w_res  = 2'b01;
        w_regw = 1'b1;
      end
      S_EXECR: begin
        w_srca = 2'b10;
        w_alu  = w_alu_dec;
      end
      S_EXECI: begin
        w_srca = 2'b10;
        w_srcb = 2'b01;
        w_alu  = w_alu_dec;
      end
      S_ALUWB:    w_regw = 1'b1;
      S_BRANCH: begin
        w_srca = 2'b10;
        w_alu  = ALU_SUB;
        w_pcw  = i_cu_zero ^ i_cu_funct3[0];
      end
      S_JAL: begin
        w_srca = 2'b01;
        w_srcb = 2'b10;
        w_pcw  = 1'b1;
      end
      S_LUI: begin
        w_srca = 2'b11;
        w_srcb = 2'b01;
      end
      S_TRAP:     w_pcw = 1'b0;
      default:    w_pcw = 1'b0;
    endcase
  end

  assign o_cu_PCWrite    = w_pcw  & ~i_cu_rst;
  assign o_cu_MemWrite   = w_memw & ~i_cu_rst;
  assign o_cu_IRWrite    = w_irw  & ~i_cu_rst;
  assign o_cu_RegWrite   = w_regw & ~i_cu_rst;
  assign o_cu_AdrSrc     = w_adr;
  assign o_cu_ResultSrc  = w_res;
  assign o_cu_ALUSrcA    = w_srca;
  assign o_cu_ALUSrcB    = w_srcb;
  assign o_cu_ImmSrc     = w_imm;
  assign o_cu_ALUControl = ALUCTRL_W'(w_alu);
  assign o_cu_illegal    = r_illegal;
  assign o_cu_state      = r_state;

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALUCTRL_W, default 4, SHALL set o_cu_ALUControl width; values below 4 are illegal.
REQ-002 Parameter MEM_HANDSHAKE, default 1, SHALL enable memory wait states when 1; when 0, i_cu_mem_ready SHALL be treated as constant 1.
REQ-003 One clock; reset is synchronous and active-high; ports SHALL be i_cu_clk (in, 1, rising-edge clock) and i_cu_rst (in, 1, synchronous active-high reset).
REQ-004 i_cu_op  in  7  opcode from instruction register.
REQ-005 i_cu_funct3  in  3  funct3 field.
REQ-006 i_cu_funct7_5  in  1  instruction bit 30.
REQ-007 i_cu_zero  in  1  ALU zero flag.
REQ-008 i_cu_mem_ready  in  1  memory access completes this cycle.
REQ-009 Outputs SHALL be:
- o_cu_PCWrite 1, o_cu_AdrSrc 1, o_cu_MemWrite 1, o_cu_IRWrite 1, o_cu_RegWrite 1
- o_cu_ResultSrc 2, o_cu_ALUSrcA 2, o_cu_ALUSrcB 2, o_cu_ImmSrc 3
- o_cu_ALUControl ALUCTRL_W
- o_cu_illegal 1 (sticky illegal-opcode flag)
- o_cu_state 4 (debug, current state code)

Function
REQ-010 The FSM SHALL use states and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, TRAP 12.
REQ-011 Transitions SHALL be:
- FETCH->DECODE on ready, else hold.
- DECODE by opcode:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other -> TRAP
- MEMADR->MEMREAD (load) or MEMWRITE (store).
- MEMREAD->MEMWB on ready, else hold.
- MEMWRITE->FETCH on ready, else hold.
- MEMWB, BRANCH -> FETCH.
- EXECR, EXECI, JAL, LUI -> ALUWB.
- ALUWB -> FETCH.
- TRAP -> TRAP.
REQ-012 Outputs SHALL be Moore-decoded from state (plus ready/zero where stated); unlisted enables SHALL be 0 and unlisted selects 00.
REQ-013 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; IRWrite=PCWrite=i_cu_mem_ready.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=01, ALUControl=ADD.
REQ-015 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUControl=ADD.
REQ-016 MEMREAD: AdrSrc=1, ResultSrc=00.
REQ-017 MEMWRITE: AdrSrc=1, ResultSrc=00; MemWrite=1 for every cycle in the state, including wait cycles.
REQ-018 MEMWB: ResultSrc=01, RegWrite=1.
REQ-019 EXECR: ALUSrcA=10, ALUSrcB=00; EXECI: ALUSrcA=10, ALUSrcB=01; both SHALL use decoded ALUControl.
REQ-020 ALUWB: ResultSrc=00, RegWrite=1.
REQ-021 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=SUB, ResultSrc=00; PCWrite=i_cu_zero XOR i_cu_funct3[0] (beq/bne).
REQ-022 JAL: ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=00, PCWrite=1.
REQ-023 LUI: ALUSrcA=11 (zero), ALUSrcB=01, ALUControl=ADD.
REQ-024 ImmSrc SHALL be combinational on opcode in every state:
- I=000, S=001, B=010, J=011, U=100
- others 000
REQ-025 ALUControl codes, zero-extended to ALUCTRL_W:
- ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9
REQ-026 Decoded ALUControl SHALL follow funct3 as:
- 000: SUB only when EXECR and funct7_5=1, else ADD
- 001: SLL
- 010: SLT
- 011: SLTU
- 100: XOR
- 101: SRA if funct7_5=1, else SRL
- 110: OR
- 111: AND
REQ-027 TRAP SHALL assert o_cu_illegal=1, hold all write enables 0, and remain until reset.
REQ-028 o_cu_state SHALL equal the current state code every cycle.

Reset
REQ-029 With i_cu_rst=1 at a rising edge, the state SHALL become FETCH and o_cu_illegal SHALL clear; reset SHALL win over any transition, including mid-wait and TRAP.
REQ-030 While i_cu_rst=1, PCWrite, MemWrite, IRWrite and RegWrite SHALL be forced 0 and all other outputs SHALL show FETCH values.

Verification
REQ-031 add x (op 0110011, f3 000, f7_5 0), ready=1 -> states 0,1,6,8,0; RegWrite=1 only in state 8; ALUControl=0 in state 6.
REQ-032 lw with ready=0 for 3 cycles in MEMREAD -> state 3 held 4 cycles, then 4 with RegWrite=1 and ResultSrc=01.
REQ-033 sw with ready low for 2 cycles -> MemWrite=1 for 3 consecutive cycles in state 5, then FETCH.
REQ-034 bne (f3 001): zero=0 -> PCWrite=1 in BRANCH; zero=1 -> PCWrite=0.
REQ-035 Opcode 0000000 -> TRAP, o_cu_illegal=1, RegWrite/MemWrite=0 for 10 cycles; reset -> state 0, illegal=0.
REQ-036 Reset asserted during MEMWRITE wait -> MemWrite=0 that cycle, state 0 next cycle.
